// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU-control decode and operand forwarding (optional: ID_EX_FORWARD_EN)
module id_ex_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic [1:0]         id_alu_op,
  input  logic [2:0]         id_funct3,
  input  logic               id_funct7_5,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic signed [31:0] id_rs1_data,
  input  logic signed [31:0] id_rs2_data,
  input  logic signed [31:0] id_imm,
  input  logic               exmem_reg_write,
  input  logic [4:0]         exmem_rd,
  input  logic [31:0]        exmem_alu_out,
  input  logic               memwb_reg_write,
  input  logic [4:0]         memwb_rd,
  input  logic [31:0]        memwb_data,
  output logic [3:0]         ALUctl,
  output logic signed [31:0] A,
  output logic signed [31:0] B,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic [4:0]         ex_rd,
  output logic [31:0]        ex_store_data
);

  // All-zero is the bubble: every control deasserted and every field cleared.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
  } stage_t;

  stage_t      stage_q;
  stage_t      stage_d;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // Next-state selection: flush beats stall, stall holds, otherwise capture decode.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid      = id_valid;
      stage_d.reg_write  = id_reg_write;
      stage_d.mem_read   = id_mem_read;
      stage_d.mem_write  = id_mem_write;
      stage_d.mem_to_reg = id_mem_to_reg;
      stage_d.alu_src    = id_alu_src;
      stage_d.alu_op     = id_alu_op;
      stage_d.funct3     = id_funct3;
      stage_d.funct7_5   = id_funct7_5;
      stage_d.rs1        = id_rs1;
      stage_d.rs2        = id_rs2;
      stage_d.rd         = id_rd;
      stage_d.rs1_data   = id_rs1_data;
      stage_d.rs2_data   = id_rs2_data;
      stage_d.imm        = id_imm;
    end
  end

  // Stage register, cleared to a bubble as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // ALU operation decode from the registered op/funct fields.
  always_comb begin
    ALUctl = 4'b1111;
    unique case (stage_q.alu_op)
      2'b00: ALUctl = 4'b0010;
      2'b01: ALUctl = 4'b0110;
      2'b10: begin
        unique case (stage_q.funct3)
          3'b000:  ALUctl = stage_q.funct7_5 ? 4'b0110 : 4'b0010;
          3'b111:  ALUctl = 4'b0000;
          3'b110:  ALUctl = 4'b0001;
          3'b010:  ALUctl = 4'b0100;
          default: ALUctl = 4'b1111;
        endcase
      end
      2'b11: begin
        unique case (stage_q.funct3)
          3'b000:  ALUctl = 4'b0010;
          3'b111:  ALUctl = 4'b0000;
          3'b110:  ALUctl = 4'b0001;
          3'b010:  ALUctl = 4'b0100;
          default: ALUctl = 4'b1111;
        endcase
      end
      default: ALUctl = 4'b1111;
    endcase
  end

`ifdef ID_EX_FORWARD_EN
  logic exmem_hit_rs1;
  logic exmem_hit_rs2;
  logic memwb_hit_rs1;
  logic memwb_hit_rs2;

  // Destination x0 never forwards; it is hardwired to zero.
  assign exmem_hit_rs1 = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs1);
  assign exmem_hit_rs2 = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs2);
  assign memwb_hit_rs1 = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rs1);
  assign memwb_hit_rs2 = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rs2);

  // Operand bypass: the younger EX/MEM result takes priority over MEM/WB.
  always_comb begin
    fwd_rs1 = stage_q.rs1_data;
    fwd_rs2 = stage_q.rs2_data;
    if (exmem_hit_rs1) begin
      fwd_rs1 = exmem_alu_out;
    end else if (memwb_hit_rs1) begin
      fwd_rs1 = memwb_data;
    end
    if (exmem_hit_rs2) begin
      fwd_rs2 = exmem_alu_out;
    end else if (memwb_hit_rs2) begin
      fwd_rs2 = memwb_data;
    end
  end
`else
  logic unused_fwd_inputs;

  // Without bypassing the registered operands go straight through.
  always_comb begin
    fwd_rs1 = stage_q.rs1_data;
    fwd_rs2 = stage_q.rs2_data;
  end

  assign unused_fwd_inputs = ^{exmem_reg_write, exmem_rd, exmem_alu_out,
                               memwb_reg_write, memwb_rd, memwb_data,
                               stage_q.rs1, stage_q.rs2};
`endif

  // Operand muxing and downstream controls.
  always_comb begin
    A             = fwd_rs1;
    B             = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    ex_valid      = stage_q.valid;
    ex_reg_write  = stage_q.reg_write;
    ex_mem_read   = stage_q.mem_read;
    ex_mem_write  = stage_q.mem_write;
    ex_mem_to_reg = stage_q.mem_to_reg;
    ex_rd         = stage_q.rd;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard testbench for id_ex_stage (either ID_EX_FORWARD_EN build)
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall, flush;
  logic id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [1:0] id_alu_op;
  logic [2:0] id_funct3;
  logic id_funct7_5;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic signed [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic exmem_reg_write, memwb_reg_write;
  logic [4:0] exmem_rd, memwb_rd;
  logic [31:0] exmem_alu_out, memwb_data;
  logic [3:0] ALUctl;
  logic signed [31:0] A, B;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0] ex_rd;
  logic [31:0] ex_store_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ALUctl(ALUctl), .A(A), .B(B),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data)
  );

  typedef struct packed {
    logic stall, flush;
    logic valid, rw, mr, mw, m2r, src;
    logic [1:0] op;
    logic [2:0] f3;
    logic f75;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic ex_rw;
    logic [4:0] ex_rd;
    logic [31:0] ex_out;
    logic wb_rw;
    logic [4:0] wb_rd;
    logic [31:0] wb_data;
  } stim_t;

  typedef struct packed {
    logic valid, rw, mr, mw, m2r, src;
    logic [1:0] op;
    logic [2:0] f3;
    logic f75;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
  } mst_t;

  typedef struct packed {
    logic [3:0] aluctl;
    logic [31:0] a, b, sd;
    logic valid, rw, mr, mw, m2r;
    logic [4:0] rd;
  } exp_t;

  mst_t  m;
  stim_t nx;
  exp_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [2:0] f3, input logic f75);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (f3 == 3'b000) return (op == 2'b10 && f75) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b010) return 4'b0100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] d, input stim_t s);
    if (FWD && s.ex_rw && s.ex_rd != 0 && s.ex_rd == r) return s.ex_out;
    if (FWD && s.wb_rw && s.wb_rd != 0 && s.wb_rd == r) return s.wb_data;
    return d;
  endfunction

  function automatic exp_t predict(input mst_t r, input stim_t s);
    exp_t e;
    logic [31:0] f1, f2;
    f1 = fwd_ref(r.rs1, r.d1, s);
    f2 = fwd_ref(r.rs2, r.d2, s);
    e.aluctl = alu_ref(r.op, r.f3, r.f75);
    e.a = f1;
    e.b = r.src ? r.imm : f2;
    e.sd = f2;
    e.valid = r.valid; e.rw = r.rw; e.mr = r.mr; e.mw = r.mw; e.m2r = r.m2r;
    e.rd = r.rd;
    return e;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    s.stall = ($urandom_range(0, 4) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    {s.valid, s.rw, s.mr, s.mw, s.m2r, s.src} = 6'($urandom);
    s.op = 2'($urandom); s.f3 = 3'($urandom); s.f75 = 1'($urandom);
    s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
    s.rd = 5'($urandom);
    s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
    s.ex_rw = 1'($urandom); s.wb_rw = 1'($urandom);
    case ($urandom_range(0, 3))
      0: s.ex_rd = m.rs1;
      1: s.ex_rd = m.rs2;
      2: s.ex_rd = 5'd0;
      default: s.ex_rd = 5'($urandom_range(0, 7));
    endcase
    case ($urandom_range(0, 3))
      0: s.wb_rd = m.rs1;
      1: s.wb_rd = m.rs2;
      2: s.wb_rd = 5'd0;
      default: s.wb_rd = 5'($urandom_range(0, 7));
    endcase
    s.ex_out = $urandom; s.wb_data = $urandom;
    return s;
  endfunction

  // Drive one cycle at the falling edge, queue the response visible until the next
  // rising edge, then advance the reference register by the stall/flush rules.
  task automatic apply(input stim_t s);
    @(negedge clk);
    stall = s.stall; flush = s.flush;
    id_valid = s.valid; id_reg_write = s.rw; id_mem_read = s.mr;
    id_mem_write = s.mw; id_mem_to_reg = s.m2r; id_alu_src = s.src;
    id_alu_op = s.op; id_funct3 = s.f3; id_funct7_5 = s.f75;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
    exmem_reg_write = s.ex_rw; exmem_rd = s.ex_rd; exmem_alu_out = s.ex_out;
    memwb_reg_write = s.wb_rw; memwb_rd = s.wb_rd; memwb_data = s.wb_data;
    sb.push_back(predict(m, s));
    if (s.flush) m = '0;
    else if (!s.stall) begin
      m.valid = s.valid; m.rw = s.rw; m.mr = s.mr; m.mw = s.mw; m.m2r = s.m2r;
      m.src = s.src; m.op = s.op; m.f3 = s.f3; m.f75 = s.f75;
      m.rs1 = s.rs1; m.rs2 = s.rs2; m.rd = s.rd;
      m.d1 = s.d1; m.d2 = s.d2; m.imm = s.imm;
    end
  endtask

  // Monitor: compares whatever the driver queued for this half-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_aluctl", 32'(ALUctl), 32'(e.aluctl));
        chk("sb_a", A, e.a);
        chk("sb_b", B, e.b);
        chk("sb_store", ex_store_data, e.sd);
        chk("sb_ctl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
            32'({e.valid, e.rw, e.mr, e.mw, e.m2r}));
        chk("sb_rd", 32'(ex_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    stim_t s;
    m = '0;
    s = quiet();
    {stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src} = '0;
    id_alu_op = '0; id_funct3 = '0; id_funct7_5 = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_alu_out = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
    #2;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_aluctl", 32'(ALUctl), 32'b0010);
    chk("reset_a", A, 32'd0);
    chk("reset_b", B, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture R-type SUB.
    s = quiet(); s.valid = 1'b1; s.op = 2'b10; s.f3 = 3'b000; s.f75 = 1'b1;
    s.d1 = 32'd7; s.d2 = 32'd3; s.rs1 = 5'd1; s.rs2 = 5'd2;
    apply(s);
    s = quiet(); s.stall = 1'b1;
    apply(s);
    #1;
    chk("cap_aluctl", 32'(ALUctl), 32'b0110);
    chk("cap_a", A, 32'd7);
    chk("cap_b", B, 32'd3);

    // addi captured, held over two stalls, then flushed while still stalled.
    s = quiet(); s.valid = 1'b1; s.rw = 1'b1; s.op = 2'b11; s.src = 1'b1;
    s.imm = 32'd5; s.d1 = 32'd10; s.rs1 = 5'd6; s.rd = 5'd9;
    apply(s);
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.stall = 1'b1; s.flush = 1'b0;
      s.ex_rw = 1'b0; s.wb_rw = 1'b0;
      apply(s);
      #1;
      chk("stall_a", A, 32'd10);
      chk("stall_b", B, 32'd5);
      chk("stall_aluctl", 32'(ALUctl), 32'b0010);
    end
    s = quiet(); s.stall = 1'b1; s.flush = 1'b1; s.valid = 1'b1; s.rw = 1'b1;
    apply(s);
    s = quiet();
    apply(s);
    #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(ex_reg_write), 32'd0);

    // Forwarding priority on rs1=5.
    s = quiet(); s.valid = 1'b1; s.rs1 = 5'd5; s.d1 = 32'd1;
    apply(s);
    s = quiet(); s.stall = 1'b1;
    s.ex_rw = 1'b1; s.ex_rd = 5'd5; s.ex_out = 32'd100;
    s.wb_rw = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'd200;
    apply(s);
    #1;
    chk("fwd_exmem", A, FWD ? 32'd100 : 32'd1);
    s.ex_rw = 1'b0;
    apply(s);
    #1;
    chk("fwd_memwb", A, FWD ? 32'd200 : 32'd1);

    // x0 never forwards; unmatched build passes registered data.
    s = quiet(); s.rs1 = 5'd0; s.d1 = 32'd0;
    apply(s);
    s = quiet(); s.stall = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd0; s.ex_out = 32'd55;
    apply(s);
    #1;
    chk("fwd_x0", A, 32'd0);
    s = quiet(); s.rs1 = 5'd3; s.d1 = 32'd9;
    apply(s);
    s = quiet(); s.stall = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd3; s.ex_out = 32'd99;
    apply(s);
    #1;
    chk("fwd_cfg", A, FWD ? 32'd99 : 32'd9);

    // Store path: immediate on B, forwarded rs2 on store data.
    s = quiet(); s.valid = 1'b1; s.mw = 1'b1; s.src = 1'b1; s.imm = 32'd8;
    s.rs2 = 5'd4; s.d2 = 32'd1;
    apply(s);
    s = quiet(); s.stall = 1'b1; s.wb_rw = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'd42;
    apply(s);
    #1;
    chk("store_b", B, 32'd8);
    chk("store_data", ex_store_data, FWD ? 32'd42 : 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) apply(rand_stim());

    // Reset asserted mid-cycle during a stall clears without a clock edge.
    s = rand_stim(); s.stall = 1'b1; s.flush = 1'b0;
    apply(s);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m = '0;
    #1;
    chk("midreset_valid", 32'(ex_valid), 32'd0);
    chk("midreset_aluctl", 32'(ALUctl), 32'b0010);
    chk("midreset_a", A, 32'd0);
    chk("midreset_b", B, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) apply(rand_stim());

    repeat (3) @(negedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have stall  input  1  hold the register contents this cycle.
REQ-004 The block SHALL have flush  input  1  replace the register contents with a bubble this cycle.
REQ-005 The block SHALL have id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  input  1 each  decode-stage qualifiers and controls.
REQ-006 The block SHALL have id_alu_op  input  2, id_funct3  input  3, id_funct7_5  input  1  ALU-control decode fields.
REQ-007 The block SHALL have id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-008 The block SHALL have id_rs1_data, id_rs2_data, id_imm  input  32 signed each  operand sources.
REQ-009 The block SHALL have exmem_reg_write  input  1, exmem_rd  input  5, exmem_alu_out  input  32  EX/MEM forwarding source.
REQ-010 The block SHALL have memwb_reg_write  input  1, memwb_rd  input  5, memwb_data  input  32  MEM/WB forwarding source.
REQ-011 The block SHALL have ALUctl  output  4, A  output  32 signed, B  output  32 signed  operands and operation for the ALU.
REQ-012 The block SHALL have ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each, ex_rd  output  5, ex_store_data  output  32  registered controls passed downstream.

Function
REQ-013 On each rising clk with flush=0 and stall=0, all id_* inputs SHALL be captured into the stage register; outputs reflect them from the next cycle (latency 1).
REQ-014 With stall=1 and flush=0, the stage register SHALL hold its value unchanged.
REQ-015 With flush=1, the stage register SHALL load a bubble (ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg = 0; all other fields 0) regardless of stall; flush wins over stall.
REQ-016 ALUctl SHALL be combinational from the registered alu_op/funct3/funct7_5: op 00 -> 0010 (ADD); op 01 -> 0110 (SUB); op 10 (R-type): funct3 000 with funct7_5=0 -> 0010, with funct7_5=1 -> 0110, 111 -> 0000, 110 -> 0001, 010 -> 0100; op 11 (I-type): funct3 000 -> 0010 (funct7_5 ignored), 111 -> 0000, 110 -> 0001, 010 -> 0100; any other combination -> 1111.
REQ-017 Forwarded rs1 value SHALL be: exmem_alu_out if exmem_reg_write=1, exmem_rd!=0 and exmem_rd==registered rs1; else memwb_data if memwb_reg_write=1, memwb_rd!=0 and memwb_rd==registered rs1; else registered rs1_data. EX/MEM has priority.
REQ-018 Forwarded rs2 value SHALL follow REQ-017 using registered rs2.
REQ-019 A SHALL equal forwarded rs1; B SHALL equal registered imm when registered alu_src=1, else forwarded rs2; ex_store_data SHALL always equal forwarded rs2.
REQ-020 Forwarding and ALUctl decode SHALL be purely combinational on the current cycle's registered fields and forwarding inputs (no added latency); forwarding SHALL not depend on ex_valid.
REQ-021 Register index 0 SHALL never match as a forwarding destination.

Reset
REQ-022 While rst_n=0, the stage register SHALL immediately (asynchronously) hold a bubble per REQ-015; ALUctl then reads 0010, A, B and ex_store_data read 0 unless forwarding of index 0 would apply (it cannot, per REQ-021).
REQ-023 Deassertion of rst_n SHALL take effect at the first rising clk after release; a reset asserted mid-stall or mid-flush SHALL override both.

Configuration
REQ-024 Macro ID_EX_FORWARD_EN defined: forwarding per REQ-017..REQ-021 SHALL be compiled in.
REQ-025 Macro ID_EX_FORWARD_EN undefined: forwarded values SHALL equal the registered rs1_data/rs2_data directly, exmem_*/memwb_* inputs SHALL be ignored, all else unchanged.

Verification
REQ-026 Reset: rst_n=0 mid-cycle -> ex_valid=0, ALUctl=0010, A=B=0 without waiting for clk.
REQ-027 Capture: id_alu_op=10, funct3=000, funct7_5=1, rs1_data=7, rs2_data=3, alu_src=0 -> next cycle ALUctl=0110, A=7, B=3.
REQ-028 Stall then flush: capture addi (imm=5), assert stall 2 cycles -> outputs unchanged; flush with stall=1 -> ex_valid=0, ex_reg_write=0.
REQ-029 Forward priority (macro defined): registered rs1=5; exmem_rd=5, exmem_alu_out=100, memwb_rd=5, memwb_data=200, both write=1 -> A=100; drop exmem_reg_write -> A=200.
REQ-030 x0 and macro off: exmem_rd=0, registered rs1=0, rs1_data=0, exmem_alu_out=55 -> A=0; rebuild without ID_EX_FORWARD_EN, rs1 match with exmem_alu_out=99 -> A equals registered rs1_data.
REQ-031 Store path: alu_src=1, imm=8, registered rs2 matched by memwb (data=42) -> B=8, ex_store_data=42.
